sprite_line_scheduler: RTL and testbench

- Sequences the per-line sprite evaluation that fills the eight-slot sprite line buffer.
- Arbitrates the single-port spriteRam between CPU (bus bridge) accesses and the line scan.
- At the end of each visible game line, scans all sprite entries for the next line and issues slot-write strobes to the line buffer.
- Reports line-done and sprite overflow to the PPU status register.

---
 rtl/sprite_line_scheduler_pkg.sv | 25 ++
 rtl/sprite_line_scheduler_row_hit.sv | 26 ++
 rtl/sprite_line_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants and scan FSM encoding
// for the sprite line scheduler.
package sprite_line_scheduler_pkg;

  localparam int SPRITE_NUM_MAX      = 64;
  localparam int SLOT_NUM_MAX        = 8;
  localparam int SPRITE_H_DEF        = 8;
  localparam int GAME_START_POSY_DEF = 0;
  localparam int VGA_POSXY_BIT       = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

  function automatic logic [7:0] sprite_y(
    input logic [31:0] entry
  );
    return entry[23:16];
  endfunction

endpackage

// File: rtl/sprite_line_scheduler_row_hit.sv
// Vertical range test: does a sprite with
// top row Y cover the row being prepared?
module sprite_row_hit
  import sprite_line_scheduler_pkg::*;
#(
  parameter int POSY_W   = VGA_POSXY_BIT,
  parameter int SPRITE_H = SPRITE_H_DEF
) (
  input  logic [POSY_W-1:0] i_row,
  input  logic [7:0]        i_y,
  output logic              o_hit
);

  localparam int PW = POSY_W + 1;

  // one spare bit so Y + height never wraps
  logic [PW-1:0] w_row;
  logic [PW-1:0] w_lo;
  logic [PW-1:0] w_hi;

  assign w_row = {1'b0, i_row};
  assign w_lo  = PW'(i_y);
  assign w_hi  = w_lo + PW'(SPRITE_H);
  assign o_hit = (w_row >= w_lo) && (w_row < w_hi);

endmodule

// File: rtl/sprite_line_scheduler.sv
// spriteRam arbiter and per-line sprite scan.
// Define SPRITE_OVERFLOW_EN to scan past a full buffer and flag overflow.
module sprite_line_scheduler
  import sprite_line_scheduler_pkg::*;
#(
  parameter int SPRITE_NUM      = SPRITE_NUM_MAX,
  parameter int SLOT_NUM        = SLOT_NUM_MAX,
  parameter int POSY_W          = VGA_POSXY_BIT,
  parameter int GAME_START_POSY = GAME_START_POSY_DEF,
  parameter int SPRITE_H        = SPRITE_H_DEF
) (
  input  logic                          clkEightRam,
  input  logic                          rstn,
  input  logic                          IsGameWindow,
  input  logic [POSY_W-1:0]             vgaPosY,
  input  logic                          cpuReq,
  input  logic                          cpuWe,
  input  logic [$clog2(SPRITE_NUM)-1:0] cpuAddr,
  input  logic [31:0]                   cpuWdata,
  output logic                          cpuGnt,
  output logic [31:0]                   cpuRdata,
  output logic [$clog2(SPRITE_NUM)-1:0] sramAddr,
  output logic                          sramWe,
  output logic [31:0]                   sramWdata,
  input  logic [31:0]                   sramRdata,
  output logic                          slotClr,
  output logic                          slotWe,
  output logic [$clog2(SLOT_NUM)-1:0]   slotIdx,
  output logic [31:0]                   slotData,
  output logic                          lineDone,
  output logic                          spriteOverflow
);

  localparam int AW = $clog2(SPRITE_NUM);
  localparam int SW = $clog2(SLOT_NUM);
  localparam int HW = SW + 1;

  localparam logic [AW-1:0]     L_LAST  = AW'(SPRITE_NUM - 1);
  localparam logic [HW-1:0]     L_FULL  = HW'(SLOT_NUM);
  localparam logic [POSY_W-1:0] L_START = POSY_W'(GAME_START_POSY);
  localparam logic [POSY_W-1:0] L_ONE   = POSY_W'(1);

  scan_state_t       r_state;
  logic              r_win0;
  logic              r_win1;
  logic              r_fall;
  logic [POSY_W-1:0] r_row;
  logic [AW-1:0]     r_addr;
  logic [HW-1:0]     r_hitCnt;
  logic              r_evalV;
  logic              r_rdPend;
  logic [31:0]       r_cpuRdata;
  logic              r_slotClr;
  logic              r_lineDone;

  logic w_idle;
  logic w_scan;
  logic w_gnt;
  logic w_hit;
  logic w_room;
  logic w_take;
  logic w_stop;
  logic w_ovf;

  assign w_idle = (r_state == ST_IDLE);
  assign w_scan = (r_state == ST_SCAN);
  assign w_gnt  = rstn & cpuReq & w_idle & ~r_fall;
  assign w_room = (r_hitCnt < L_FULL);
  assign w_take = r_evalV & w_hit & w_room;

  sprite_row_hit #(
    .POSY_W   (POSY_W),
    .SPRITE_H (SPRITE_H)
  ) u_row_hit (
    .i_row (r_row),
    .i_y   (sprite_y(sramRdata)),
    .o_hit (w_hit)
  );

  assign cpuGnt    = w_gnt;
  assign sramAddr  = w_scan ? r_addr
                   : (w_gnt ? cpuAddr : '0);
  assign sramWe    = w_gnt & cpuWe;
  assign sramWdata = (w_gnt & cpuWe) ? cpuWdata : '0;
  assign cpuRdata  = r_rdPend ? sramRdata : r_cpuRdata;

  assign slotWe   = w_take;
  assign slotIdx  = w_take ? r_hitCnt[SW-1:0] : '0;
  assign slotData = w_take ? sramRdata : '0;
  assign slotClr  = r_slotClr;
  assign lineDone = r_lineDone;

  assign spriteOverflow = w_ovf;

`ifdef SPRITE_OVERFLOW_EN
  logic r_ovf;

  assign w_stop = (r_addr == L_LAST);
  assign w_ovf  = r_ovf;

  // sticky flag for hits beyond the last slot
  always_ff @(posedge clkEightRam) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_ovf <= 1'b0;
    end else if (r_evalV & w_hit & ~w_room) begin
      r_ovf <= 1'b1;
    end
  end
`else
  localparam logic [HW-1:0] L_LASTSLOT = HW'(SLOT_NUM - 1);

  assign w_stop = (r_addr == L_LAST)
                | (w_take & (r_hitCnt == L_LASTSLOT));
  assign w_ovf  = 1'b0;
`endif

  // window falling-edge detector
  always_ff @(posedge clkEightRam) begin
    if (!rstn) begin
      r_win0 <= 1'b0;
      r_win1 <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_win0 <= IsGameWindow;
      r_win1 <= r_win0;
      r_fall <= r_win1 & ~r_win0;
    end
  end

  // hold CPU read data after its sram cycle
  always_ff @(posedge clkEightRam) begin
    if (!rstn) begin
      r_rdPend   <= 1'b0;
      r_cpuRdata <= '0;
    end else begin
      r_rdPend <= w_gnt & ~cpuWe;
      if (r_rdPend) begin
        r_cpuRdata <= sramRdata;
      end
    end
  end

  // scan sequencer: clear, scan, drain, done
  always_ff @(posedge clkEightRam) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_addr     <= '0;
      r_hitCnt   <= '0;
      r_evalV    <= 1'b0;
      r_slotClr  <= 1'b0;
      r_lineDone <= 1'b0;
    end else begin
      r_slotClr  <= 1'b0;
      r_lineDone <= 1'b0;
      r_evalV    <= w_scan;
      if (w_take) begin
        r_hitCnt <= r_hitCnt + HW'(1);
      end
      unique case (r_state)
        ST_IDLE: begin
          if (r_fall) begin
            r_row     <= vgaPosY - L_START + L_ONE;
            r_slotClr <= 1'b1;
            r_state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          r_addr   <= '0;
          r_hitCnt <= '0;
          r_state  <= ST_SCAN;
        end
        ST_SCAN: begin
          r_addr <= r_addr + AW'(1);
          if (w_stop) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_lineDone <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler:
// directed lines, CPU arbitration and reset abort.
module tb_sprite_line_scheduler;

  logic        clk;
  logic        rstn;
  logic        IsGameWindow;
  logic [9:0]  vgaPosY;
  logic        cpuReq;
  logic        cpuWe;
  logic [5:0]  cpuAddr;
  logic [31:0] cpuWdata;
  logic        cpuGnt;
  logic [31:0] cpuRdata;
  logic [5:0]  sramAddr;
  logic        sramWe;
  logic [31:0] sramWdata;
  logic [31:0] sramRdata;
  logic        slotClr;
  logic        slotWe;
  logic [2:0]  slotIdx;
  logic [31:0] slotData;
  logic        lineDone;
  logic        spriteOverflow;

  logic [31:0] mem [64];
  logic [34:0] exp_q [$];
  logic [34:0] e;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done = 0;

  sprite_line_scheduler dut (
    .clkEightRam    (clk),
    .rstn           (rstn),
    .IsGameWindow   (IsGameWindow),
    .vgaPosY        (vgaPosY),
    .cpuReq         (cpuReq),
    .cpuWe          (cpuWe),
    .cpuAddr        (cpuAddr),
    .cpuWdata       (cpuWdata),
    .cpuGnt         (cpuGnt),
    .cpuRdata       (cpuRdata),
    .sramAddr       (sramAddr),
    .sramWe         (sramWe),
    .sramWdata      (sramWdata),
    .sramRdata      (sramRdata),
    .slotClr        (slotClr),
    .slotWe         (slotWe),
    .slotIdx        (slotIdx),
    .slotData       (slotData),
    .lineDone       (lineDone),
    .spriteOverflow (spriteOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // spriteRam model, one cycle read latency
  always @(posedge clk) begin
    if (sramWe) mem[sramAddr] <= sramWdata;
    sramRdata <= mem[sramAddr];
  end

  // monitor: pop expected slot writes
  always @(negedge clk) begin
    if (lineDone) begin
      done_cnt++;
      last_done = cyc;
    end
    if (slotWe) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL slot_extra act idx=%0d data=%h exp none",
                 slotIdx, slotData);
      end else begin
        e = exp_q.pop_front();
        if ({slotIdx, slotData} !== e) begin
          fails++;
          $display("FAIL slot_write act idx=%0d data=%h exp idx=%0d data=%h",
                   slotIdx, slotData, e[34:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [110:0] outs();
    return {cpuGnt, sramAddr, sramWe, sramWdata, slotClr,
            slotWe, slotIdx, slotData, lineDone,
            spriteOverflow, cpuRdata};
  endfunction

  function automatic logic [31:0] ent(input int idx, input int y);
    return {8'hA5, 8'(y), 8'h00, 8'(idx)};
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 64; i++) begin
      mem[i] = {8'h00, 8'd200, 8'h00, 8'(i)};
    end
  endtask

  task automatic push(input int slot, input int idx);
    exp_q.push_back({3'(slot), mem[idx]});
  endtask

  task automatic run_line(input logic [9:0] vy,
                          input bit pre_cpu,
                          input bit mid_cpu,
                          input int exp_dur,
                          input bit exp_ovf);
    int c0;
    int dc0;
    int clr_c;
    int gnt_c;
    bit ok;
    clr_c = 0;
    gnt_c = 0;
    vgaPosY = vy;
    IsGameWindow = 1'b1;
    repeat (3) @(posedge clk);
    #1 IsGameWindow = 1'b0;
    c0 = cyc;
    dc0 = done_cnt;
    if (pre_cpu) begin
      @(posedge clk);
      #1 cpuReq = 1'b1;
      cpuWe = 1'b1;
      cpuAddr = 6'd60;
      cpuWdata = 32'h00C8_0ABC;
      @(negedge clk);
      check("pre_fall_gnt", cpuGnt, 1);
      @(posedge clk);
      #1 cpuReq = 1'b0;
      cpuWe = 1'b0;
    end
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (slotClr) begin
        ok = 1;
        clr_c = cyc;
      end
    end
    check("clr_seen", 32'(ok), 1);
    check("clr_latency", clr_c - c0, 3);
    if (mid_cpu) begin
      repeat (10) @(posedge clk);
      #1 cpuReq = 1'b1;
      cpuWe = 1'b0;
      cpuAddr = 6'd3;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk);
        if (cpuGnt) begin
          ok = 1;
          gnt_c = cyc;
        end
      end
      check("mid_gnt_seen", 32'(ok), 1);
      check("mid_gnt_cycle", gnt_c, last_done + 1);
      @(posedge clk);
      #1 cpuReq = 1'b0;
      @(negedge clk);
      check("mid_rdata", cpuRdata, mem[3]);
    end
    for (int i = 0; i < 200 && done_cnt == dc0; i++) begin
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("done_count", done_cnt - dc0, 1);
    check("done_latency", last_done - clr_c, exp_dur);
    check("overflow", 32'(spriteOverflow), 32'(exp_ovf));
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit ok;
    int dc0;
    rstn = 1'b0;
    IsGameWindow = 1'b0;
    vgaPosY = '0;
    cpuReq = 1'b0;
    cpuWe = 1'b0;
    cpuAddr = '0;
    cpuWdata = '0;
    init_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_all_zero_in", 32'(|outs()), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(cpuGnt), 0);
    check("rst_linedone", 32'(lineDone), 0);
    check("rst_all_zero", 32'(|outs()), 0);

    // CPU write then read of entry 5
    @(posedge clk);
    #1 cpuReq = 1'b1;
    cpuWe = 1'b1;
    cpuAddr = 6'd5;
    cpuWdata = 32'h0012_0000;
    @(negedge clk);
    check("wr_gnt", 32'(cpuGnt), 1);
    check("wr_sram_we", 32'(sramWe), 1);
    check("wr_sram_addr", 32'(sramAddr), 5);
    check("wr_sram_data", sramWdata, 32'h0012_0000);
    @(posedge clk);
    #1 cpuWe = 1'b0;
    @(negedge clk);
    check("rd_gnt", 32'(cpuGnt), 1);
    check("rd_sram_we", 32'(sramWe), 0);
    @(posedge clk);
    #1 cpuReq = 1'b0;
    @(negedge clk);
    check("rd_data", cpuRdata, 32'h0012_0000);

    // three hits on row 23, CPU before fall and during scan
    init_mem();
    mem[3] = ent(3, 16);
    mem[10] = ent(10, 16);
    mem[40] = ent(40, 16);
    push(0, 3);
    push(1, 10);
    push(2, 40);
    run_line(10'd22, 1'b1, 1'b1, 66, 1'b0);

    // Y range boundaries
    init_mem();
    mem[1] = ent(1, 250);
    mem[2] = ent(2, 0);
    push(0, 2);
    run_line(10'd1, 1'b0, 1'b0, 66, 1'b0);
    push(0, 2);
    run_line(10'd6, 1'b0, 1'b0, 66, 1'b0);
    run_line(10'd7, 1'b0, 1'b0, 66, 1'b0);

    // ten hits on one row
    init_mem();
    for (int i = 20; i < 30; i++) mem[i] = ent(i, 0);
    for (int i = 0; i < 8; i++) push(i, 20 + i);
`ifdef SPRITE_OVERFLOW_EN
    run_line(10'd0, 1'b0, 1'b0, 66, 1'b1);
`else
    run_line(10'd0, 1'b0, 1'b0, 31, 1'b0);
`endif

    // reset while scanning address 20
    init_mem();
    mem[3] = ent(3, 16);
    mem[10] = ent(10, 16);
    mem[40] = ent(40, 16);
    push(0, 3);
    push(1, 10);
    dc0 = done_cnt;
    vgaPosY = 10'd22;
    IsGameWindow = 1'b1;
    repeat (3) @(posedge clk);
    #1 IsGameWindow = 1'b0;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (sramAddr == 6'd20) ok = 1;
    end
    check("midrst_addr20_seen", 32'(ok), 1);
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_all_zero", 32'(|outs()), 0);
    rstn = 1'b1;
    repeat (80) @(negedge clk);
    check("midrst_no_done", done_cnt - dc0, 0);
    check("midrst_exp_q", exp_q.size(), 0);
    @(posedge clk);
    #1 cpuReq = 1'b1;
    cpuWe = 1'b0;
    cpuAddr = 6'd10;
    @(negedge clk);
    check("midrst_idle_gnt", 32'(cpuGnt), 1);
    @(posedge clk);
    #1 cpuReq = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
